reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
Parametrised power-on and soft-reset sequencer for the user project area. It replaces a fixed single-domain reset-hold counter with N reset domains that are released in a fixed order, each a programmable number of cycles after the previous one. It adds a Logic-Analyzer soft-reset request and a boot-select latch that is captured when the first domain leaves reset. It sits between the clock/reset muxing and the core(s), pad-direction logic and peripherals.

Parameters:
NUM_DOMAINS, 3, number of reset domains (1..8); domain 0 released first
CNT_WIDTH, 12, width of the shared delay counter
HOLD_CYCLES, 4095, cycles from internal reset release to domain 0 release (1..2^CNT_WIDTH-1)
STAGGER_CYCLES, 16, cycles between successive domain releases (1..2^CNT_WIDTH-1)
SYNC_STAGES, 2, flop depth of the reset-deassert synchroniser and the soft-request synchroniser (>=2)

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  reset, asynchronous, active-high
soft_rst_req  in  1  soft reset request from LA, asynchronous level, active-high
boot_sel_i  in  1  boot-address select from LA, asynchronous level
domain_rst_n  out  NUM_DOMAINS  per-domain reset, active-low
pad_oeb_force  out  1  high while any domain is in reset; forces output pads to input
boot_sel_o  out  1  boot_sel_i captured at domain 0 release
ready  out  1  high once all domains are released
soft_rst_count  out  8  saturating count of soft resets since the last wb_rst_i

Behaviour:
- Reset is asynchronous and active-high. While wb_rst_i=1 the outputs hold: domain_rst_n=0, pad_oeb_force=1, ready=0, boot_sel_o=0, soft_rst_count=0. The state is HOLD with cnt=0 and idx=0. The synchroniser chains are set to 1.
- Deassert synchroniser: an SYNC_STAGES-flop chain is asynchronously set by wb_rst_i and shifts in 0. Its output is rst_int. While rst_int=1 the block holds the reset values above (soft_rst_count is not cleared by rst_int alone).
- soft_rst_req passes through an SYNC_STAGES-flop synchroniser to give sreq. A rising edge of sreq is one soft-reset event.
- Single FSM, with all outputs registered:
  - HOLD: cnt increments each cycle. When cnt==HOLD_CYCLES-1:
    - domain_rst_n[0] goes to 1 and boot_sel_o captures the synchronised boot_sel_i.
    - cnt goes to 0 and idx goes to 1.
    - Next state is STAGGER, or RUN if NUM_DOMAINS==1.
  - STAGGER: cnt increments. When cnt==STAGGER_CYCLES-1:
    - domain_rst_n[idx] goes to 1, cnt goes to 0 and idx increments.
    - When idx==NUM_DOMAINS-1 is released, the next state is RUN.
  - RUN: ready=1 and pad_oeb_force=0. Both take effect on the same edge as the last domain release.
- Release timing: domain k goes high on clock edge SYNC_STAGES + HOLD_CYCLES + k*STAGGER_CYCLES. Edges are counted from the first rising edge with wb_rst_i=0 (that edge is edge 1).
- Soft reset: an sreq rising edge in any state does the following on the next edge:
  - all domain_rst_n go to 0, pad_oeb_force=1, ready=0;
  - state goes to HOLD with cnt=0 and idx=0;
  - soft_rst_count increments, saturating at 255.
- While sreq remains 1, the FSM holds HOLD with cnt=0. Sequencing restarts when sreq falls.
- A soft reset during HOLD or STAGGER also restarts from scratch; partially released domains are re-asserted.
- If wb_rst_i asserts at any time, it immediately forces all reset values asynchronously and overrides everything else.
- boot_sel_o stays stable from capture until the next wb_rst_i or soft reset. It is recaptured at each domain 0 release.
- domain_rst_n is monotonic per sequence: once released, a domain stays released until a reset or soft-reset event.
- soft_rst_count is cleared only by wb_rst_i.

Test Plan:
1. NUM_DOMAINS=3, HOLD_CYCLES=8, STAGGER_CYCLES=4, SYNC_STAGES=2; deassert wb_rst_i → domain_rst_n[0] rises at edge 10, [1] at 14, [2] at 18; ready=1 and pad_oeb_force=0 at edge 18; nothing rises earlier.
2. Same config; boot_sel_i=1 before edge 10, then toggle it to 0 at edge 12 → boot_sel_o=1 from edge 10 and stays 1.
3. In RUN, pulse soft_rst_req high for 3 cycles → all domain_rst_n drop 3 edges after the request rises (2 sync + 1); soft_rst_count=1; the release sequence repeats, with domain 0 released 8 edges after sreq falls.
4. Soft request at edge 15 (domains 0 and 1 released) → both drop, domain 2 never released early, full sequence restarts, ready stays 0 until the new completion.
5. Assert wb_rst_i asynchronously mid-STAGGER (between clock edges) → all outputs reach reset values without a clock edge; soft_rst_count=0.
6. NUM_DOMAINS=1, HOLD_CYCLES=1 → domain_rst_n[0] and ready rise together at edge 3; 300 soft pulses → soft_rst_count saturates at 255.

Source files
------------

// File: rtl/reset_sequencer_if.sv
// Reset sequencer handshake bundle: LA requests in, per-domain resets and status out.
// master = sequencer side, slave = LA/consumer side.
interface reset_sequencer_if #(
   parameter int NUM_DOMAINS = 3
);
   logic                   soft_rst_req;
   logic                   boot_sel_i;
   logic [NUM_DOMAINS-1:0] domain_rst_n;
   logic                   pad_oeb_force;
   logic                   boot_sel_o;
   logic                   ready;
   logic [7:0]             soft_rst_count;

   modport master (
      input  soft_rst_req,
      input  boot_sel_i,
      output domain_rst_n,
      output pad_oeb_force,
      output boot_sel_o,
      output ready,
      output soft_rst_count
   );

   modport slave (
      output soft_rst_req,
      output boot_sel_i,
      input  domain_rst_n,
      input  pad_oeb_force,
      input  boot_sel_o,
      input  ready,
      input  soft_rst_count
   );
endinterface

// File: rtl/reset_sequencer.sv
// Staggered multi-domain reset release with LA soft-reset and boot-select latch.
// All outputs registered; wb_rst_i clears everything asynchronously.
module reset_sequencer #(
   parameter int NUM_DOMAINS    = 3,
   parameter int CNT_WIDTH      = 12,
   parameter int HOLD_CYCLES    = 4095,
   parameter int STAGGER_CYCLES = 16,
   parameter int SYNC_STAGES    = 2
) (
   input logic                wb_clk_i,
   input logic                wb_rst_i,
   reset_sequencer_if.master  bus
);
   localparam logic [1:0] S_HOLD = 2'd0;
   localparam logic [1:0] S_STAG = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;

   localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] STAG_LAST = CNT_WIDTH'(STAGGER_CYCLES - 1);
   localparam logic [3:0]           LAST_IDX  = 4'(NUM_DOMAINS - 1);

   logic [SYNC_STAGES-1:0] r_rst_sync;
   logic [SYNC_STAGES-1:0] r_req_sync;
   logic [SYNC_STAGES-1:0] r_boot_sync;
   logic                   r_sreq_d;

   logic [1:0]             r_state;
   logic [CNT_WIDTH-1:0]   r_cnt;
   logic [3:0]             r_idx;
   logic [NUM_DOMAINS-1:0] r_dom;
   logic                   r_pad;
   logic                   r_ready;
   logic                   r_boot;
   logic [7:0]             r_count;

   logic                   w_rst_int;
   logic                   w_sreq;
   logic                   w_boot;
   logic [NUM_DOMAINS-1:0] w_idx_bit;

   assign w_rst_int = r_rst_sync[SYNC_STAGES-1];
   assign w_sreq    = r_req_sync[SYNC_STAGES-1];
   assign w_boot    = r_boot_sync[SYNC_STAGES-1];
   assign w_idx_bit = NUM_DOMAINS'(1) << r_idx;

   // Request chain resets high so no spurious edge is seen on release
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_rst_sync  <= '1;
         r_req_sync  <= '1;
         r_boot_sync <= '0;
         r_sreq_d    <= 1'b1;
      end else begin
         r_rst_sync  <= {r_rst_sync[SYNC_STAGES-2:0], 1'b0};
         r_req_sync  <= {r_req_sync[SYNC_STAGES-2:0], bus.soft_rst_req};
         r_boot_sync <= {r_boot_sync[SYNC_STAGES-2:0], bus.boot_sel_i};
         r_sreq_d    <= w_sreq;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state <= S_HOLD;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_dom   <= '0;
         r_pad   <= 1'b1;
         r_ready <= 1'b0;
         r_boot  <= 1'b0;
         r_count <= '0;
      end else if (w_rst_int) begin
         r_state <= S_HOLD;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_dom   <= '0;
         r_pad   <= 1'b1;
         r_ready <= 1'b0;
         r_boot  <= 1'b0;
      end else if (w_sreq) begin
         // Level holds the sequence parked; only the rising edge is counted
         r_state <= S_HOLD;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_dom   <= '0;
         r_pad   <= 1'b1;
         r_ready <= 1'b0;
         r_boot  <= 1'b0;
         if (!r_sreq_d && r_count != 8'hFF)
            r_count <= r_count + 8'd1;
      end else begin
         unique case (r_state)
            S_HOLD: begin
               if (r_cnt == HOLD_LAST) begin
                  r_dom[0] <= 1'b1;
                  r_boot   <= w_boot;
                  r_cnt    <= '0;
                  r_idx    <= 4'd1;
                  if (NUM_DOMAINS == 1) begin
                     r_state <= S_RUN;
                     r_ready <= 1'b1;
                     r_pad   <= 1'b0;
                  end else begin
                     r_state <= S_STAG;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_STAG: begin
               if (r_cnt == STAG_LAST) begin
                  r_dom <= r_dom | w_idx_bit;
                  r_cnt <= '0;
                  r_idx <= r_idx + 4'd1;
                  if (r_idx == LAST_IDX) begin
                     r_state <= S_RUN;
                     r_ready <= 1'b1;
                     r_pad   <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RUN: begin
               r_ready <= 1'b1;
               r_pad   <= 1'b0;
            end
            default: begin
               r_state <= S_HOLD;
               r_cnt   <= '0;
               r_idx   <= '0;
            end
         endcase
      end
   end

   assign bus.domain_rst_n   = r_dom;
   assign bus.pad_oeb_force  = r_pad;
   assign bus.ready          = r_ready;
   assign bus.boot_sel_o     = r_boot;
   assign bus.soft_rst_count = r_count;
endmodule
